// File: rtl/uart_tx_sequencer_if.sv
// uart_tx_sequencer_if: groups the signals between the UART transmit frame
// sequencer and its neighbours: the byte requester (tx_data/tx_valid/tx_ready),
// the baud timer (baud_tick/timer_en) and the line/status outputs.
// The master modport is the requester/timer side.
// The slave modport is the sequencer itself.
interface uart_tx_sequencer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 baud_tick;
  logic                 timer_en;
  logic                 tx_serial;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid, baud_tick,
    input  tx_ready, timer_en, tx_serial, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid, baud_tick,
    output tx_ready, timer_en, tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: frame sequencer for the UART transmit path.
// It accepts one byte per valid/ready handshake while idle.
// It serialises the byte LSB-first as: start bit, data bits, optional parity bit,
// then the stop bits.
// It keeps the baud timer enabled for the whole frame and advances one bit per
// baud_tick.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state; parity
// sense chosen by ODD_PARITY). Without it ODD_PARITY has no effect.
module uart_tx_sequencer #(
  parameter int unsigned DATA_BITS  = 8,  // 5..9
  parameter int unsigned STOP_BITS  = 1,  // 1 or 2
  parameter int unsigned ODD_PARITY = 0   // 1 = odd, 0 = even
) (
  input logic               clk,
  input logic               ResetN,
  uart_tx_sequencer_if.slave tx_if
);

  localparam int unsigned        CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]         STOP_LAST = 2'(STOP_BITS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_q,     state_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [CNT_W-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [1:0]           stop_cnt_q,  stop_cnt_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_done_q,   tx_done_d;
  logic [1:0]           stop_inc;
  logic                 accept;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD = (ODD_PARITY != 0);
  logic parity_q, parity_d;
`else
  // Parity sense has no meaning without the parity feature.
  logic unused_odd_parity;
  assign unused_odd_parity = (ODD_PARITY != 0);
`endif

  // The handshake completes only in IDLE.
  // tx_valid offered mid-frame is simply not taken.
  assign accept   = tx_if.tx_valid && (state_q == S_IDLE);
  assign stop_inc = stop_cnt_q + 2'd1;

  // Next-state and datapath: one bit advance per baud_tick outside IDLE.
  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    tx_serial_d = tx_serial_q;
    tx_done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_serial_d = 1'b1;
        if (accept) begin
          state_d     = S_START;
          shift_d     = tx_if.tx_data;
          bit_cnt_d   = '0;
          stop_cnt_d  = '0;
          tx_serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d    = (^tx_if.tx_data) ^ ODD;
`endif
        end
      end

      S_START: begin
        if (tx_if.baud_tick) begin
          state_d     = S_DATA;
          tx_serial_d = shift_q[0];
          shift_d     = shift_q >> 1;
          bit_cnt_d   = '0;
        end
      end

      S_DATA: begin
        if (tx_if.baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d     = S_PARITY;
            tx_serial_d = parity_q;
`else
            state_d     = S_STOP;
            tx_serial_d = 1'b1;
`endif
          end else begin
            bit_cnt_d   = bit_cnt_q + 1'b1;
            tx_serial_d = shift_q[0];
            shift_d     = shift_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tx_if.baud_tick) begin
          state_d     = S_STOP;
          tx_serial_d = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_serial_d = 1'b1;
        if (tx_if.baud_tick) begin
          if (stop_inc == STOP_LAST) begin
            state_d    = S_IDLE;
            stop_cnt_d = '0;
            tx_done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_inc;
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
  end

  // State, shift register, counters and registered line/done outputs.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      // NOTE: the shift register is an ordinary flop bank, so it is cleared with the rest.
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      tx_serial_q <= 1'b1;
      tx_done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_serial_q <= tx_serial_d;
      tx_done_q   <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // The status outputs and the timer enable decode straight from the state register.
  // timer_en therefore drops in the same cycle that the state returns to IDLE.
  assign tx_if.tx_ready  = (state_q == S_IDLE);
  assign tx_if.tx_busy   = (state_q != S_IDLE);
  assign tx_if.timer_en  = (state_q != S_IDLE);
  assign tx_if.tx_serial = tx_serial_q;
  assign tx_if.tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: drives two sequencers (STOP_BITS=1 and STOP_BITS=2)
// with identical stimulus.
// Each sequencer is compared every cycle against a frame-level reference model.
// The model builds each frame's expected bit list at accept, then consumes one
// list entry per baud_tick.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_sequencer;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned ODD_PARITY = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       drv_valid = 1'b0;
  logic       drv_tick = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;
  int tick_period = 16;
  int tick_cnt = 0;
  int done_cnt_s1 = 0;

  always #5 clk = ~clk;

  uart_tx_sequencer_if #(.DATA_BITS(DATA_BITS)) if_s1 ();
  uart_tx_sequencer_if #(.DATA_BITS(DATA_BITS)) if_s2 ();

  assign if_s1.tx_data   = drv_data;
  assign if_s1.tx_valid  = drv_valid;
  assign if_s1.baud_tick = drv_tick;
  assign if_s2.tx_data   = drv_data;
  assign if_s2.tx_valid  = drv_valid;
  assign if_s2.baud_tick = drv_tick;

  uart_tx_sequencer #(.DATA_BITS(DATA_BITS), .STOP_BITS(1), .ODD_PARITY(ODD_PARITY)) u_dut_s1 (
    .clk    (clk),
    .ResetN (rst_n),
    .tx_if  (if_s1)
  );

  uart_tx_sequencer #(.DATA_BITS(DATA_BITS), .STOP_BITS(2), .ODD_PARITY(ODD_PARITY)) u_dut_s2 (
    .clk    (clk),
    .ResetN (rst_n),
    .tx_if  (if_s2)
  );

  // Frame-level model: seq holds the line levels that follow the start bit.
  typedef struct {
    bit          busy;
    int          pos;
    int          nbits;
    logic [15:0] seq;
    bit          line;
    bit          done;
  } model_t;

  model_t m1, m2;

  function automatic model_t model_reset();
    model_t r;
    r.busy = 1'b0; r.pos = 0; r.nbits = 0; r.seq = '0; r.line = 1'b1; r.done = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input bit valid, input logic [7:0] data,
                                        input bit tick, input int stop_bits);
    model_t n = m;
    n.done = 1'b0;
    if (!m.busy) begin
      if (valid) begin
        n.busy = 1'b1; n.line = 1'b0; n.pos = 0; n.nbits = 0; n.seq = '0;
        for (int i = 0; i < int'(DATA_BITS); i++) begin
          n.seq[n.nbits] = data[i];
          n.nbits = n.nbits + 1;
        end
`ifdef UART_TX_PARITY_EN
        n.seq[n.nbits] = (^data) ^ (ODD_PARITY != 0);
        n.nbits = n.nbits + 1;
`endif
        for (int s = 0; s < stop_bits; s++) begin
          n.seq[n.nbits] = 1'b1;
          n.nbits = n.nbits + 1;
        end
      end
    end else if (tick) begin
      if (m.pos == m.nbits) begin
        n.busy = 1'b0; n.done = 1'b1; n.line = 1'b1;
      end else begin
        n.line = m.seq[m.pos];
        n.pos  = m.pos + 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_s1(input model_t m);
    check("s1 tx_serial", if_s1.tx_serial, m.line);
    check("s1 tx_ready",  if_s1.tx_ready,  !m.busy);
    check("s1 tx_busy",   if_s1.tx_busy,   m.busy);
    check("s1 timer_en",  if_s1.timer_en,  m.busy);
    check("s1 tx_done",   if_s1.tx_done,   m.done);
  endtask

  task automatic check_s2(input model_t m);
    check("s2 tx_serial", if_s2.tx_serial, m.line);
    check("s2 tx_ready",  if_s2.tx_ready,  !m.busy);
    check("s2 tx_busy",   if_s2.tx_busy,   m.busy);
    check("s2 timer_en",  if_s2.timer_en,  m.busy);
    check("s2 tx_done",   if_s2.tx_done,   m.done);
  endtask

  // One clock: present the tick, clock both models, compare just after the edge.
  task automatic step();
    drv_tick = (tick_cnt >= tick_period - 1);
    @(posedge clk);
    m1 = model_step(m1, drv_valid, drv_data, drv_tick, 1);
    m2 = model_step(m2, drv_valid, drv_data, drv_tick, 2);
    tick_cnt = drv_tick ? 0 : tick_cnt + 1;
    #1;
    if (if_s1.tx_done === 1'b1) done_cnt_s1++;
    check_s1(m1);
    check_s2(m2);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((m1.busy || m2.busy || if_s1.tx_busy !== 1'b0 || if_s2.tx_busy !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", {if_s1.tx_busy, if_s2.tx_busy}, 2'b00);
  endtask

  task automatic send_and_wait(input logic [7:0] data);
    drv_valid = 1'b1;
    drv_data  = data;
    step();
    drv_valid = 1'b0;
    drv_data  = 8'($urandom);
    run_until_idle(800);
  endtask

  logic [9:0]  a5_line;
  int          a5_n;
  int          done_base;
  int          guard;
  bit          prev_busy;
  logic [7:0]  directed [6] = '{8'h07, 8'h03, 8'hFF, 8'h00, 8'h80, 8'h01};

  initial begin
    m1 = model_reset();
    m2 = model_reset();

    // Reset state with tx_valid low.
    repeat (2) @(posedge clk);
    #1;
    check_s1(m1);
    check_s2(m2);
    #2 rst_n = 1'b1;
    repeat (3) step();

    // 0xA5 with a baud tick every 16 clocks; capture the s1 line once per bit.
    tick_period = 16;
    a5_line = '0;
    a5_n = 0;
    done_base = done_cnt_s1;
    drv_valid = 1'b1;
    drv_data  = 8'hA5;
    step();
    drv_valid = 1'b0;
    a5_line[0] = if_s1.tx_serial;
    a5_n = 1;
    guard = 0;
    while ((m1.busy || m2.busy) && guard < 800) begin
      prev_busy = if_s1.tx_busy;
      step();
      if (drv_tick && prev_busy && if_s1.tx_busy && a5_n < 10) begin
        a5_line[a5_n] = if_s1.tx_serial;
        a5_n++;
      end
      guard++;
    end
    check("a5_idle_timeout", {if_s1.tx_busy, if_s2.tx_busy}, 2'b00);
`ifndef UART_TX_PARITY_EN
    check("a5_line_bits", a5_line, 10'b1101001010);
`endif
    check("a5_done_pulses", done_cnt_s1 - done_base, 1);

    // Directed bytes, including the parity examples.
    foreach (directed[i]) begin
      tick_period = 2 + int'($urandom_range(0, 10));
      send_and_wait(directed[i]);
    end

    // 0x5A, then 0x3C held valid through the whole frame.
    // s2 must start 0x3C the cycle after its ready rises; nothing offered mid-frame may be taken.
    tick_period = 6;
    drv_valid = 1'b1;
    drv_data  = 8'h5A;
    step();
    drv_data = 8'h3C;
    guard = 0;
    while (!m2.done && guard < 400) begin
      step();
      guard++;
    end
    check("b2b_ready_rise_s2", if_s2.tx_ready, 1'b1);
    step();
    check("b2b_start_line_s2", if_s2.tx_serial, 1'b0);
    check("b2b_start_busy_s2", if_s2.tx_busy, 1'b1);
    drv_valid = 1'b0;
    run_until_idle(800);

    // Reset asserted while data bit 3 is on the line.
    tick_period = 8;
    drv_valid = 1'b1;
    drv_data  = 8'hF0;
    step();
    drv_valid = 1'b0;
    guard = 0;
    while (m1.pos != 4 && guard < 200) begin
      step();
      guard++;
    end
    check("rst_mid_pre_line", if_s1.tx_serial, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    m1 = model_reset();
    m2 = model_reset();
    check_s1(m1);
    check_s2(m2);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    done_base = done_cnt_s1;
    repeat (20) step();
    check("rst_mid_no_done", done_cnt_s1 - done_base, 0);

    // Random traffic: random bytes, random valid, random baud periods (including ticks in IDLE).
    for (int blk = 0; blk < 30; blk++) begin
      tick_period = 1 + int'($urandom_range(0, 11));
      for (int c = 0; c < 120; c++) begin
        drv_valid = ($urandom_range(0, 3) == 0);
        drv_data  = 8'($urandom);
        step();
      end
    end
    drv_valid = 1'b0;
    run_until_idle(800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
